// File: rtl/mips_controller.sv
// Multicycle MIPS control unit: sequences fetch/decode/execute/memory/writeback,
// stretches memory states by MEM_LATENCY wait cycles and counts retired instructions.
module mips_controller #(
    parameter int MEM_LATENCY = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  op,
    input  logic [5:0]  funct,
    input  logic        zero,
    output logic        alusrca,
    output logic [1:0]  alusrcb,
    output logic [1:0]  pcsource,
    output logic        pcen,
    output logic        memtoreg,
    output logic        regdst,
    output logic        iord,
    output logic        regwrite,
    output logic        irwrite,
    output logic        memread,
    output logic        memwrite,
    output logic [2:0]  alucontrol,
    output logic        illegal,
    output logic [3:0]  state,
    output logic [31:0] instret
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        JUMP    = 4'd9,
        ADDIEX  = 4'd10,
        ADDIWB  = 4'd11
    } state_t;

    state_t      state_r;
    state_t      next_s;
    logic [3:0]  wait_r;
    logic        final_s;
    logic        mem_state_s;
    logic        retire_s;
    logic        pcwrite_s;
    logic        branch_s;
    logic        irwrite_s;
    logic        regwrite_s;
    logic        memread_s;
    logic        memwrite_s;
    logic        illegal_s;

    assign final_s = (wait_r == 4'(MEM_LATENCY));
    assign state   = state_r;

    // State register, memory wait counter and retired-instruction counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= FETCH;
            wait_r  <= 4'd0;
            instret <= 32'd0;
        end else begin
            state_r <= next_s;
            // The counter only survives while a memory state is still waiting,
            // so every entry into FETCH/MEMRD/MEMWR sees it at zero.
            if (mem_state_s && !final_s) begin
                wait_r <= wait_r + 4'd1;
            end else begin
                wait_r <= 4'd0;
            end
            if (retire_s) begin
                instret <= instret + 32'd1;
            end else begin
                instret <= instret;
            end
        end
    end

    // Next-state and per-state Moore decode.
    always_comb begin
        next_s      = FETCH;
        mem_state_s = 1'b0;
        retire_s    = 1'b0;
        pcwrite_s   = 1'b0;
        branch_s    = 1'b0;
        irwrite_s   = 1'b0;
        regwrite_s  = 1'b0;
        memread_s   = 1'b0;
        memwrite_s  = 1'b0;
        illegal_s   = 1'b0;
        alusrca     = 1'b0;
        alusrcb     = 2'b00;
        pcsource    = 2'b00;
        memtoreg    = 1'b0;
        regdst      = 1'b0;
        iord        = 1'b0;
        alucontrol  = 3'b010;
        case (state_r)
            FETCH: begin
                mem_state_s = 1'b1;
                iord        = 1'b1;
                memread_s   = 1'b1;
                alusrcb     = 2'b01;
                if (final_s) begin
                    irwrite_s = 1'b1;
                    pcwrite_s = 1'b1;
                    next_s    = DECODE;
                end else begin
                    next_s    = FETCH;
                end
            end
            DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    6'b100011, 6'b101011: next_s = MEMADR;
                    6'b000000:            next_s = EXECUTE;
                    6'b000100:            next_s = BRANCH;
                    6'b000010:            next_s = JUMP;
                    6'b001000:            next_s = ADDIEX;
                    default: begin
                        illegal_s = 1'b1;
                        next_s    = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                if (op == 6'b100011) begin
                    next_s = MEMRD;
                end else begin
                    next_s = MEMWR;
                end
            end
            MEMRD: begin
                mem_state_s = 1'b1;
                memread_s   = 1'b1;
                if (final_s) begin
                    next_s = MEMWB;
                end else begin
                    next_s = MEMRD;
                end
            end
            MEMWB: begin
                memtoreg   = 1'b1;
                regwrite_s = 1'b1;
                retire_s   = 1'b1;
            end
            MEMWR: begin
                mem_state_s = 1'b1;
                memwrite_s  = 1'b1;
                if (final_s) begin
                    retire_s = 1'b1;
                    next_s   = FETCH;
                end else begin
                    next_s   = MEMWR;
                end
            end
            EXECUTE: begin
                alusrca = 1'b1;
                next_s  = ALUWB;
                case (funct)
                    6'b100000: alucontrol = 3'b010;
                    6'b100010: alucontrol = 3'b110;
                    6'b100100: alucontrol = 3'b000;
                    6'b100101: alucontrol = 3'b001;
                    6'b101010: alucontrol = 3'b111;
                    default: begin
                        illegal_s = 1'b1;
                        next_s    = FETCH;
                    end
                endcase
            end
            ALUWB: begin
                regdst     = 1'b1;
                regwrite_s = 1'b1;
                retire_s   = 1'b1;
            end
            BRANCH: begin
                alusrca    = 1'b1;
                alucontrol = 3'b110;
                pcsource   = 2'b01;
                branch_s   = 1'b1;
                retire_s   = 1'b1;
            end
            JUMP: begin
                pcsource  = 2'b10;
                pcwrite_s = 1'b1;
                retire_s  = 1'b1;
            end
            ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                next_s  = ADDIWB;
            end
            ADDIWB: begin
                regwrite_s = 1'b1;
                retire_s   = 1'b1;
            end
            default: begin
                next_s = FETCH;
            end
        endcase
    end

    // Enables are held off for as long as reset is asserted.
    assign pcen     = reset & (pcwrite_s | (branch_s & zero));
    assign irwrite  = reset & irwrite_s;
    assign regwrite = reset & regwrite_s;
    assign memread  = reset & memread_s;
    assign memwrite = reset & memwrite_s;
    assign illegal  = reset & illegal_s;

endmodule

// File: tb/tb_mips_controller.sv
// Bench for mips_controller: table of instructions on a MEM_LATENCY=0 instance,
// plus hand sequences for wait states (MEM_LATENCY=2) and reset mid-instruction.
module tb_mips_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [5:0]  op = 6'd0;
    logic [5:0]  funct = 6'd0;
    logic        zero = 1'b0;

    logic        a_alusrca, a_pcen, a_memtoreg, a_regdst, a_iord, a_regwrite;
    logic        a_irwrite, a_memread, a_memwrite, a_illegal;
    logic [1:0]  a_alusrcb, a_pcsource;
    logic [2:0]  a_alucontrol;
    logic [3:0]  a_state;
    logic [31:0] a_instret;

    logic        b_alusrca, b_pcen, b_memtoreg, b_regdst, b_iord, b_regwrite;
    logic        b_irwrite, b_memread, b_memwrite, b_illegal;
    logic [1:0]  b_alusrcb, b_pcsource;
    logic [2:0]  b_alucontrol;
    logic [3:0]  b_state;
    logic [31:0] b_instret;

    mips_controller #(.MEM_LATENCY(0)) dut_a (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .alusrca(a_alusrca), .alusrcb(a_alusrcb), .pcsource(a_pcsource), .pcen(a_pcen),
        .memtoreg(a_memtoreg), .regdst(a_regdst), .iord(a_iord), .regwrite(a_regwrite),
        .irwrite(a_irwrite), .memread(a_memread), .memwrite(a_memwrite),
        .alucontrol(a_alucontrol), .illegal(a_illegal), .state(a_state), .instret(a_instret)
    );

    mips_controller #(.MEM_LATENCY(2)) dut_b (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .alusrca(b_alusrca), .alusrcb(b_alusrcb), .pcsource(b_pcsource), .pcen(b_pcen),
        .memtoreg(b_memtoreg), .regdst(b_regdst), .iord(b_iord), .regwrite(b_regwrite),
        .irwrite(b_irwrite), .memread(b_memread), .memwrite(b_memwrite),
        .alucontrol(b_alucontrol), .illegal(b_illegal), .state(b_state), .instret(b_instret)
    );

    always #5 clk = ~clk;

    logic [16:0] a_ctrl, b_ctrl;
    assign a_ctrl = {a_alusrca, a_alusrcb, a_pcsource, a_pcen, a_memtoreg, a_regdst, a_iord,
                     a_regwrite, a_irwrite, a_memread, a_memwrite, a_alucontrol, a_illegal};
    assign b_ctrl = {b_alusrca, b_alusrcb, b_pcsource, b_pcen, b_memtoreg, b_regdst, b_iord,
                     b_regwrite, b_irwrite, b_memread, b_memwrite, b_alucontrol, b_illegal};

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic [5:0]  funct;
        logic        zero;
        int          ncyc;
        logic [23:0] seq;
        bit          retire;
    } vec_t;

    typedef struct {
        logic [3:0]  st;
        logic [16:0] ctrl;
    } exp_t;

    vec_t        vecs[13];
    exp_t        sbq[$];
    int          n_vec = 0;
    int          n_miss = 0;
    logic [31:0] icount;

    // Expected control word for one cycle, written out from the state table.
    function automatic logic [16:0] exp_ctrl(input logic [3:0] st, input logic fin,
                                             input logic [5:0] o, input logic [5:0] f,
                                             input logic z);
        logic       sa, pe, mt, rd, io, rw, iw, mr, mw, il;
        logic [1:0] sb, ps;
        logic [2:0] al;
        {sa, pe, mt, rd, io, rw, iw, mr, mw, il} = 10'd0;
        sb = 2'b00;
        ps = 2'b00;
        al = 3'b010;
        case (st)
            4'd0: begin io = 1'b1; mr = 1'b1; sb = 2'b01; iw = fin; pe = fin; end
            4'd1: begin
                sb = 2'b11;
                il = !(o == 6'h23 || o == 6'h2b || o == 6'h00 || o == 6'h04 ||
                       o == 6'h02 || o == 6'h08);
            end
            4'd2: begin sa = 1'b1; sb = 2'b10; end
            4'd3: begin mr = 1'b1; end
            4'd4: begin mt = 1'b1; rw = 1'b1; end
            4'd5: begin mw = 1'b1; end
            4'd6: begin
                sa = 1'b1;
                if (f == 6'h20)      al = 3'b010;
                else if (f == 6'h22) al = 3'b110;
                else if (f == 6'h24) al = 3'b000;
                else if (f == 6'h25) al = 3'b001;
                else if (f == 6'h2a) al = 3'b111;
                else                 il = 1'b1;
            end
            4'd7:  begin rd = 1'b1; rw = 1'b1; end
            4'd8:  begin sa = 1'b1; al = 3'b110; ps = 2'b01; pe = z; end
            4'd9:  begin ps = 2'b10; pe = 1'b1; end
            4'd10: begin sa = 1'b1; sb = 2'b10; end
            4'd11: begin rw = 1'b1; end
            default: begin end
        endcase
        return {sa, sb, ps, pe, mt, rd, io, rw, iw, mr, mw, al, il};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Runs one instruction on dut_a from FETCH; called just after a falling edge.
    task automatic run_vec(input vec_t v);
        exp_t e;
        exp_t g;
        op    = v.op;
        funct = v.funct;
        zero  = v.zero;
        for (int c = 0; c < v.ncyc; c++) begin
            e.st   = v.seq[4*c +: 4];
            e.ctrl = exp_ctrl(e.st, 1'b1, v.op, v.funct, v.zero);
            sbq.push_back(e);
            #1;
            g = sbq.pop_front();
            chk($sformatf("%s c%0d state", v.name, c), {28'd0, a_state}, {28'd0, g.st});
            chk($sformatf("%s c%0d ctrl", v.name, c), {15'd0, a_ctrl}, {15'd0, g.ctrl});
            @(negedge clk);
        end
        if (v.retire) icount = icount + 32'd1;
        #1;
        chk($sformatf("%s end state", v.name), {28'd0, a_state}, 32'd0);
        chk($sformatf("%s instret", v.name), a_instret, icount);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t        e;
        exp_t        g;
        logic [3:0]  sw_st [8];
        logic        sw_fin [8];

        vecs[0]  = '{"lw",      6'h23, 6'h00, 1'b0, 5, 24'h043210, 1'b1};
        vecs[1]  = '{"sw",      6'h2b, 6'h00, 1'b0, 4, 24'h005210, 1'b1};
        vecs[2]  = '{"sub",     6'h00, 6'h22, 1'b0, 4, 24'h007610, 1'b1};
        vecs[3]  = '{"slt",     6'h00, 6'h2a, 1'b0, 4, 24'h007610, 1'b1};
        vecs[4]  = '{"add",     6'h00, 6'h20, 1'b0, 4, 24'h007610, 1'b1};
        vecs[5]  = '{"and",     6'h00, 6'h24, 1'b0, 4, 24'h007610, 1'b1};
        vecs[6]  = '{"or",      6'h00, 6'h25, 1'b0, 4, 24'h007610, 1'b1};
        vecs[7]  = '{"addi",    6'h08, 6'h00, 1'b0, 4, 24'h00BA10, 1'b1};
        vecs[8]  = '{"beq_t",   6'h04, 6'h00, 1'b1, 3, 24'h000810, 1'b1};
        vecs[9]  = '{"beq_nt",  6'h04, 6'h00, 1'b0, 3, 24'h000810, 1'b1};
        vecs[10] = '{"j",       6'h02, 6'h00, 1'b0, 3, 24'h000910, 1'b1};
        vecs[11] = '{"bad_op",  6'h3f, 6'h00, 1'b0, 2, 24'h000010, 1'b0};
        vecs[12] = '{"bad_fn",  6'h00, 6'h3f, 1'b0, 3, 24'h000610, 1'b0};

        // Reset held for three cycles.
        reset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst a state", {28'd0, a_state}, 32'd0);
        chk("rst a instret", a_instret, 32'd0);
        chk("rst a enables", {26'd0, a_pcen, a_irwrite, a_regwrite, a_memread, a_memwrite, a_illegal}, 32'd0);
        chk("rst b state", {28'd0, b_state}, 32'd0);
        chk("rst b enables", {26'd0, b_pcen, b_irwrite, b_regwrite, b_memread, b_memwrite, b_illegal}, 32'd0);
        reset = 1'b1;
        #1;
        chk("post-rst fetch", {28'd0, a_memread, a_iord, a_irwrite, a_pcen}, 32'hf);
        icount = 32'd0;

        for (int i = 0; i < 13; i++) begin
            run_vec(vecs[i]);
        end

        // sw with two wait cycles per memory access on dut_b.
        reset = 1'b0;
        @(negedge clk);
        #1;
        reset = 1'b1;
        op    = 6'h2b;
        funct = 6'h00;
        zero  = 1'b0;
        sw_st  = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd5};
        sw_fin = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int c = 0; c < 8; c++) begin
            e.st   = sw_st[c];
            e.ctrl = exp_ctrl(sw_st[c], sw_fin[c], 6'h2b, 6'h00, 1'b0);
            sbq.push_back(e);
            #1;
            g = sbq.pop_front();
            chk($sformatf("sw_wait c%0d state", c), {28'd0, b_state}, {28'd0, g.st});
            chk($sformatf("sw_wait c%0d ctrl", c), {15'd0, b_ctrl}, {15'd0, g.ctrl});
            @(negedge clk);
        end
        #1;
        chk("sw_wait end state", {28'd0, b_state}, 32'd0);
        chk("sw_wait instret", b_instret, 32'd1);

        // Reset asserted while dut_a sits in MEMRD of a lw.
        reset = 1'b0;
        @(negedge clk);
        #1;
        reset = 1'b1;
        op    = 6'h23;
        repeat (3) @(negedge clk);
        #1;
        chk("abort pre state", {28'd0, a_state}, 32'd3);
        #1;
        reset = 1'b0;
        #1;
        chk("abort async state", {28'd0, a_state}, 32'd0);
        chk("abort regwrite", {31'd0, a_regwrite}, 32'd0);
        @(negedge clk);
        #1;
        chk("abort held state", {28'd0, a_state}, 32'd0);
        chk("abort held regwrite", {31'd0, a_regwrite}, 32'd0);
        chk("abort instret", a_instret, 32'd0);
        reset = 1'b1;
        icount = 32'd0;
        run_vec(vecs[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
